// File: rtl/thor2023_mem_req_splitter.sv
// ----------------------------------------------------------------------------
// thor2023_pkg / thor2023_mem_req_splitter
//
// Purpose:
//   Pops one memory_arg_t at a time from the memory request queue head and
//   issues it to the data-cache/bus port as one or two 16-byte aligned
//   accesses. An access straddling a 16-byte line-half boundary is split into
//   two; the load halves are re-merged, shifted down to bit 0 and sign- or
//   zero-extended before being returned to writeback as a single completion.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   q_valid, q_o  queue head valid / entry
//   q_rd          combinational pop strobe to the queue
//   rollback      per-thread rollback; suppresses completion of that thread
//   cpu_req*      aligned bus request (adr[3:0]=0, 16-bit sel, 128-bit res)
//   cpu_ack       bus request accepted
//   cpu_resp*     bus response, res = aligned 128-bit line-half
//   resp, resp_v  completed request (res aligned and extended), 1-cycle pulse
//   resp_err      completion was a timeout, qualified by resp_v
//   busy          a request is in flight
// ----------------------------------------------------------------------------
package thor2023_pkg;

    localparam int NTHREADS = 4;
    localparam int THREAD_W = 2;

    typedef enum logic [1:0] {
        MR_NOP   = 2'd0,
        MR_LOAD  = 2'd1,
        MR_LOADZ = 2'd2,
        MR_STORE = 2'd3
    } memop_t;

    typedef enum logic [2:0] {
        byt   = 3'd0,
        wyde  = 3'd1,
        tetra = 3'd2,
        octa  = 3'd3,
        hexi  = 3'd4
    } memsz_t;

    typedef struct packed {
        logic                v;
        logic [THREAD_W-1:0] thread;
        memop_t              func;
        memsz_t              sz;
        logic [31:0]         adr;
        logic [15:0]         sel;
        logic [127:0]        res;
    } memory_arg_t;

endpackage

module thor2023_mem_req_splitter
    import thor2023_pkg::*;
#(
    parameter int AWID    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                q_valid,
    input  memory_arg_t         q_o,
    output logic                q_rd,
    input  logic [NTHREADS-1:0] rollback,
    output memory_arg_t         cpu_req,
    output logic                cpu_req_v,
    input  logic                cpu_ack,
    input  memory_arg_t         cpu_resp,
    input  logic                cpu_resp_v,
    output memory_arg_t         resp,
    output logic                resp_v,
    output logic                resp_err,
    output logic                busy
);

    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE0 = 3'd1,
        WAIT0  = 3'd2,
        ISSUE1 = 3'd3,
        WAIT1  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    memory_arg_t     r_req;
    logic [127:0]    r_r0;
    logic [127:0]    r_r1;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic            r_kill;

    logic [3:0]      w_off;
    logic [4:0]      w_size;
    logic [31:0]     w_mask32;
    logic [31:0]     w_sel32;
    logic [255:0]    w_dat256;
    logic            w_split;
    logic [31:0]     w_adr0;
    logic [31:0]     w_adr1;
    logic [255:0]    w_shift;
    logic [127:0]    w_lo;
    logic [127:0]    w_ext;
    logic            w_sgn;
    logic            w_timeout;
    logic            w_rb;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Access positioning and result alignment
    // ------------------------------------------------------------------
    assign w_off = r_req.adr[3:0];

    always_comb begin
        case (r_req.sz)
            byt:     w_size = 5'd1;
            wyde:    w_size = 5'd2;
            tetra:   w_size = 5'd4;
            octa:    w_size = 5'd8;
            hexi:    w_size = 5'd16;
            default: w_size = 5'd8;
        endcase
    end

    assign w_mask32 = (32'h1 << w_size) - 32'h1;
    assign w_sel32  = w_mask32 << w_off;
    assign w_dat256 = {128'h0, r_req.res} << {w_off, 3'b000};
    assign w_split  = ({1'b0, w_off} + w_size) > 5'd16;

    always_comb begin
        w_adr0              = r_req.adr;
        w_adr0[3:0]         = 4'h0;
        w_adr1              = r_req.adr;
        w_adr1[AWID-1:4]    = r_req.adr[AWID-1:4] + (AWID-4)'(1);
        w_adr1[3:0]         = 4'h0;
    end

    assign w_shift = {r_r1, r_r0} >> {w_off, 3'b000};
    assign w_lo    = w_shift[127:0];
    assign w_sgn   = (r_req.func == MR_LOAD);

    always_comb begin
        case (r_req.sz)
            byt:     w_ext = {{120{w_sgn & w_lo[7]}},  w_lo[7:0]};
            wyde:    w_ext = {{112{w_sgn & w_lo[15]}}, w_lo[15:0]};
            tetra:   w_ext = {{96{w_sgn & w_lo[31]}},  w_lo[31:0]};
            hexi:    w_ext = w_lo;
            default: w_ext = {{64{w_sgn & w_lo[63]}},  w_lo[63:0]};
        endcase
    end

    // r_cnt holds the number of completed wait cycles, so the timeout fires
    // on the TIMEOUT-th cycle spent in a WAIT state.
    assign w_timeout = (r_cnt + CW'(1)) == CW'(TIMEOUT);
    assign w_rb      = rollback[r_req.thread];

    assign w_unused = ^{cpu_resp.v, cpu_resp.thread, cpu_resp.func,
                        cpu_resp.sz, cpu_resp.adr, cpu_resp.sel, r_req.sel};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (q_valid && q_o.v) w_state_nxt = ISSUE0;
            ISSUE0: if (cpu_ack) w_state_nxt = WAIT0;
            WAIT0: begin
                if (cpu_resp_v)     w_state_nxt = w_split ? ISSUE1 : DONE;
                else if (w_timeout) w_state_nxt = DONE;
            end
            ISSUE1: if (cpu_ack) w_state_nxt = WAIT1;
            WAIT1:  if (cpu_resp_v || w_timeout) w_state_nxt = DONE;
            DONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        q_rd      = 1'b0;
        cpu_req_v = 1'b0;
        cpu_req   = '0;
        resp      = '0;
        resp_v    = 1'b0;
        resp_err  = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: q_rd = q_valid;
            ISSUE0: begin
                cpu_req_v   = 1'b1;
                cpu_req     = r_req;
                cpu_req.adr = w_adr0;
                cpu_req.sel = w_sel32[15:0];
                cpu_req.res = w_dat256[127:0];
            end
            ISSUE1: begin
                cpu_req_v   = 1'b1;
                cpu_req     = r_req;
                cpu_req.adr = w_adr1;
                cpu_req.sel = w_sel32[31:16];
                cpu_req.res = w_dat256[255:128];
            end
            DONE: begin
                resp = r_req;
                if (r_req.func == MR_LOAD || r_req.func == MR_LOADZ)
                    resp.res = w_ext;
                // A rollback arriving in the DONE cycle itself also kills it.
                resp_v   = ~r_kill & ~w_rb;
                resp_err = r_err;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, response capture, timeout and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= '0;
            r_r0   <= '0;
            r_r1   <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_kill <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (q_valid) begin
                        r_req  <= q_o;
                        r_r0   <= '0;
                        r_r1   <= '0;
                        r_err  <= 1'b0;
                        r_kill <= 1'b0;
                    end
                end
                ISSUE0, ISSUE1: r_cnt <= '0;
                WAIT0, WAIT1: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (cpu_resp_v) begin
                        if (r_state == WAIT0) r_r0 <= cpu_resp.res;
                        else                  r_r1 <= cpu_resp.res;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (r_state != IDLE && w_rb)
                r_kill <= 1'b1;
        end
    end

endmodule

// File: tb/tb_thor2023_mem_req_splitter.sv
// ----------------------------------------------------------------------------
// tb_thor2023_mem_req_splitter
//
// Directed bench: a table of requests with hand-computed bus accesses and
// results, played through a zero-wait bus responder, followed by hand-written
// sequences for discard, rollback, timeout and mid-transaction reset.
// ----------------------------------------------------------------------------
module tb_thor2023_mem_req_splitter;
    import thor2023_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                q_valid;
    memory_arg_t         q_o;
    logic                q_rd;
    logic [NTHREADS-1:0] rollback;
    memory_arg_t         cpu_req;
    logic                cpu_req_v;
    logic                cpu_ack;
    memory_arg_t         cpu_resp;
    logic                cpu_resp_v;
    memory_arg_t         resp;
    logic                resp_v;
    logic                resp_err;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    thor2023_mem_req_splitter #(.AWID(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .q_valid    (q_valid),
        .q_o        (q_o),
        .q_rd       (q_rd),
        .rollback   (rollback),
        .cpu_req    (cpu_req),
        .cpu_req_v  (cpu_req_v),
        .cpu_ack    (cpu_ack),
        .cpu_resp   (cpu_resp),
        .cpu_resp_v (cpu_resp_v),
        .resp       (resp),
        .resp_v     (resp_v),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    typedef struct {
        memop_t       func;
        memsz_t       sz;
        logic [31:0]  adr;
        logic [127:0] wdat;
        logic [127:0] r0;
        logic [127:0] r1;
        logic         split;
        logic [31:0]  a0;
        logic [15:0]  s0;
        logic [127:0] d0;
        logic [31:0]  a1;
        logic [15:0]  s1;
        logic [127:0] d1;
        logic [127:0] res;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic memory_arg_t mk(input memop_t f, input memsz_t s, input logic [31:0] a,
                                       input logic [127:0] d, input logic [1:0] thr);
        memory_arg_t m;
        m        = '0;
        m.v      = 1'b1;
        m.thread = thr;
        m.func   = f;
        m.sz     = s;
        m.adr    = a;
        m.sel    = 16'hFFFF;
        m.res    = d;
        return m;
    endfunction

    task automatic give_resp(input logic [127:0] d);
        cpu_resp     = '0;
        cpu_resp.res = d;
        cpu_resp_v   = 1'b1;
    endtask

    // Plays one table entry through a zero-wait bus; fixed cycle positions
    // double as latency checks.
    task automatic run_vec(input int idx);
        vec_t v;
        v       = vecs[idx];
        q_o     = mk(v.func, v.sz, v.adr, v.wdat, 2'd1);
        q_valid = 1'b1;
        #1 chk($sformatf("v%0d q_rd", idx), 128'(q_rd), 128'd1);
        tick;
        q_valid = 1'b0;
        q_o     = '0;
        #1;
        chk($sformatf("v%0d req_v0", idx), 128'(cpu_req_v), 128'd1);
        chk($sformatf("v%0d adr0", idx), 128'(cpu_req.adr), 128'(v.a0));
        chk($sformatf("v%0d sel0", idx), 128'(cpu_req.sel), 128'(v.s0));
        chk($sformatf("v%0d dat0", idx), cpu_req.res, v.d0);
        cpu_ack = 1'b1;
        tick;
        cpu_ack = 1'b0;
        give_resp(v.r0);
        #1 chk($sformatf("v%0d req_v_wait0", idx), 128'(cpu_req_v), 128'd0);
        tick;
        cpu_resp_v = 1'b0;
        if (v.split) begin
            #1;
            chk($sformatf("v%0d req_v1", idx), 128'(cpu_req_v), 128'd1);
            chk($sformatf("v%0d adr1", idx), 128'(cpu_req.adr), 128'(v.a1));
            chk($sformatf("v%0d sel1", idx), 128'(cpu_req.sel), 128'(v.s1));
            chk($sformatf("v%0d dat1", idx), cpu_req.res, v.d1);
            cpu_ack = 1'b1;
            tick;
            cpu_ack = 1'b0;
            give_resp(v.r1);
            tick;
            cpu_resp_v = 1'b0;
        end
        #1;
        chk($sformatf("v%0d resp_v", idx), 128'(resp_v), 128'd1);
        chk($sformatf("v%0d resp_res", idx), resp.res, v.res);
        chk($sformatf("v%0d resp_adr", idx), 128'(resp.adr), 128'(v.adr));
        chk($sformatf("v%0d resp_err", idx), 128'(resp_err), 128'd0);
        tick;
        chk($sformatf("v%0d resp_v_after", idx), 128'(resp_v), 128'd0);
        chk($sformatf("v%0d busy_after", idx), 128'(busy), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            func      sz     adr           wdat
        //            r0
        //            r1
        //            split a0            s0        d0
        //                  a1            s1        d1
        //            res
        vecs[0] = '{MR_LOAD, octa, 32'h0000_1000, 128'h0,
                    {64'h5555_5555_5555_5555, 64'h8000_0000_0000_0001}, 128'h0,
                    1'b0, 32'h0000_1000, 16'h00FF, 128'h0,
                    32'h0, 16'h0, 128'h0,
                    {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001}};
        vecs[1] = '{MR_LOADZ, tetra, 32'h0000_100E, 128'h0,
                    {16'hAABB, {14{8'h77}}}, {{14{8'h66}}, 16'hCCDD},
                    1'b1, 32'h0000_1000, 16'hC000, 128'h0,
                    32'h0000_1010, 16'h0003, 128'h0,
                    128'hCCDD_AABB};
        vecs[2] = '{MR_STORE, wyde, 32'h0000_201F, 128'h1234,
                    128'hDEAD, 128'hBEEF,
                    1'b1, 32'h0000_2010, 16'h8000, {8'h34, 120'h0},
                    32'h0000_2020, 16'h0001, 128'h12,
                    128'h1234};
        vecs[3] = '{MR_LOAD, byt, 32'h0000_3005, 128'h0,
                    128'h0000_0000_0000_0000_0000_807F_0000_0000, 128'h0,
                    1'b0, 32'h0000_3000, 16'h0020, 128'h0,
                    32'h0, 16'h0, 128'h0,
                    {{120{1'b1}}, 8'h80}};
        vecs[4] = '{MR_LOAD, hexi, 32'h0000_4008, 128'h0,
                    {64'hAAAA_BBBB_CCCC_DDDD, 64'h9999_9999_9999_9999},
                    {64'h7777_7777_7777_7777, 64'h1111_2222_3333_4444},
                    1'b1, 32'h0000_4000, 16'hFF00, 128'h0,
                    32'h0000_4010, 16'h00FF, 128'h0,
                    128'h1111_2222_3333_4444_AAAA_BBBB_CCCC_DDDD};
        vecs[5] = '{MR_LOAD, wyde, 32'h0000_500E, 128'h0,
                    {16'h8001, {14{8'h33}}}, 128'h0,
                    1'b0, 32'h0000_5000, 16'hC000, 128'h0,
                    32'h0, 16'h0, 128'h0,
                    {{112{1'b1}}, 16'h8001}};
        vecs[6] = '{MR_LOADZ, octa, 32'hFFFF_FFFC, 128'h0,
                    {32'h89AB_CDEF, {12{8'h44}}}, {{12{8'h22}}, 32'h0123_4567},
                    1'b1, 32'hFFFF_FFF0, 16'hF000, 128'h0,
                    32'h0000_0000, 16'h000F, 128'h0,
                    128'h0123_4567_89AB_CDEF};

        rst        = 1'b1;
        q_valid    = 1'b0;
        q_o        = '0;
        rollback   = '0;
        cpu_ack    = 1'b0;
        cpu_resp   = '0;
        cpu_resp_v = 1'b0;
        tick;
        tick;
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst req_v", 128'(cpu_req_v), 128'd0);
        chk("rst req", 128'(cpu_req), 128'd0);
        chk("rst resp_v", 128'(resp_v), 128'd0);
        chk("rst resp", 128'(resp), 128'd0);
        chk("rst resp_err", 128'(resp_err), 128'd0);
        chk("rst q_rd", 128'(q_rd), 128'd0);
        rst = 1'b0;
        tick;

        // Stray bus strobes in IDLE must not start anything.
        cpu_ack = 1'b1;
        give_resp(128'h1);
        tick;
        cpu_ack    = 1'b0;
        cpu_resp_v = 1'b0;
        chk("idle stray busy", 128'(busy), 128'd0);
        chk("idle stray resp_v", 128'(resp_v), 128'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Invalid head entry is popped and discarded; next entry popped next cycle.
        q_o     = mk(MR_LOAD, octa, 32'h0000_6000, 128'h0, 2'd0);
        q_o.v   = 1'b0;
        q_valid = 1'b1;
        #1 chk("disc q_rd", 128'(q_rd), 128'd1);
        tick;
        chk("disc busy", 128'(busy), 128'd0);
        chk("disc req_v", 128'(cpu_req_v), 128'd0);
        chk("disc resp_v", 128'(resp_v), 128'd0);
        q_o = mk(MR_LOADZ, byt, 32'h0000_6003, 128'h0, 2'd0);
        #1 chk("disc q_rd2", 128'(q_rd), 128'd1);
        tick;
        q_valid = 1'b0;
        chk("disc2 req_v", 128'(cpu_req_v), 128'd1);
        chk("disc2 adr", 128'(cpu_req.adr), 128'h6000);
        cpu_ack = 1'b1;
        tick;
        cpu_ack = 1'b0;
        give_resp(128'hF1_0000_00);
        tick;
        cpu_resp_v = 1'b0;
        chk("disc2 resp_v", 128'(resp_v), 128'd1);
        chk("disc2 res", resp.res, 128'hF1);
        tick;

        // Rollback during WAIT0 of a split load: both accesses run, no completion.
        q_o     = mk(MR_LOAD, tetra, 32'h0000_700E, 128'h0, 2'd2);
        q_valid = 1'b1;
        tick;
        q_valid = 1'b0;
        cpu_ack = 1'b1;
        tick;
        cpu_ack     = 1'b0;
        rollback[2] = 1'b1;
        chk("rb resp_v wait0", 128'(resp_v), 128'd0);
        tick;
        rollback = '0;
        give_resp(128'h0);
        tick;
        cpu_resp_v = 1'b0;
        chk("rb resp_v wait0b", 128'(resp_v), 128'd0);
        tick;
        chk("rb req_v1", 128'(cpu_req_v), 128'd1);
        chk("rb adr1", 128'(cpu_req.adr), 128'h7010);
        cpu_ack = 1'b1;
        tick;
        cpu_ack = 1'b0;
        give_resp(128'h0);
        tick;
        cpu_resp_v = 1'b0;
        chk("rb done busy", 128'(busy), 128'd1);
        chk("rb done resp_v", 128'(resp_v), 128'd0);
        tick;
        chk("rb idle busy", 128'(busy), 128'd0);
        chk("rb idle resp_v", 128'(resp_v), 128'd0);

        // Timeout: no response, error completion 4 cycles after entering WAIT0.
        q_o     = mk(MR_LOAD, octa, 32'h0000_8000, 128'h0, 2'd3);
        q_valid = 1'b1;
        tick;
        q_valid = 1'b0;
        cpu_ack = 1'b1;
        tick;
        cpu_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("to wait%0d resp_v", c), 128'(resp_v), 128'd0);
            chk($sformatf("to wait%0d busy", c), 128'(busy), 128'd1);
            tick;
        end
        chk("to resp_v", 128'(resp_v), 128'd1);
        chk("to resp_err", 128'(resp_err), 128'd1);
        chk("to resp_adr", 128'(resp.adr), 128'h8000);
        tick;
        chk("to idle busy", 128'(busy), 128'd0);
        chk("to idle err", 128'(resp_err), 128'd0);

        // Asynchronous reset in the middle of WAIT0.
        q_o     = mk(MR_LOAD, octa, 32'h0000_9000, 128'h0, 2'd0);
        q_valid = 1'b1;
        tick;
        q_valid = 1'b0;
        cpu_ack = 1'b1;
        tick;
        cpu_ack = 1'b0;
        chk("mrst pre busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("mrst busy", 128'(busy), 128'd0);
        chk("mrst req_v", 128'(cpu_req_v), 128'd0);
        chk("mrst resp", 128'(resp), 128'd0);
        tick;
        rst = 1'b0;
        tick;
        chk("mrst after busy", 128'(busy), 128'd0);
        chk("mrst after resp_v", 128'(resp_v), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
